// File: rtl/pixel_fb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_fb_writer                                                          |
// | Clips rasterizer pixels to the frame and turns them into buffered        |
// | framebuffer word writes. Define PIXEL_FB_CLIP_STATS_EN for clip_count.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_fb_writer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [15:0]       pixelX,
  input  logic [15:0]       pixelY,
  input  logic [7:0]        pix_color,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  output logic [15:0]       pix_count,
  output logic [15:0]       clip_count,
  output logic              busy,
  output logic              done
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]   c_one     = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         width_q, width_d;
  logic [15:0]         height_q, height_d;
  logic [15:0]         pix_count_q, pix_count_d;
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]    count_q, count_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_d [FIFO_DEPTH];
  logic [7:0]          fifo_data_q [FIFO_DEPTH];
  logic [7:0]          fifo_data_d [FIFO_DEPTH];

  logic                w_start;
  logic                w_empty;
  logic                w_full;
  logic                w_xfer;
  logic                w_in_range;
  logic                w_push;
  logic                w_pop;
  logic                w_busy;
  logic [ADDR_W-1:0]   w_px;
  logic [ADDR_W-1:0]   w_py;
  logic [ADDR_W-1:0]   w_wd;
  logic [ADDR_W-1:0]   w_push_addr;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == c_full);
  assign w_busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign w_start    = (state_q == ST_IDLE) && frame_start;

  assign pix_ready  = (state_q == ST_RUN) && !w_full;
  assign w_xfer     = pix_valid && pix_ready;
  // A zero width or height makes every compare fail, so the whole frame clips.
  assign w_in_range = (pixelX < width_q) && (pixelY < height_q);
  assign w_push     = w_xfer && w_in_range;
  assign w_pop      = mem_req && mem_gnt;

  // y*w+x of two 16-bit operands never exceeds 32 bits, so evaluating it
  // modulo 2^ADDR_W yields exactly the low ADDR_W bits of the full product.
  assign w_px        = ADDR_W'(pixelX);
  assign w_py        = ADDR_W'(pixelY);
  assign w_wd        = ADDR_W'(width_q);
  assign w_push_addr = (w_py * w_wd) + w_px;

  assign mem_req   = w_busy && !w_empty;
  assign mem_addr  = mem_req ? fifo_addr_q[rd_ptr_q] : '0;
  assign mem_wdata = mem_req ? fifo_data_q[rd_ptr_q] : '0;
  assign busy      = w_busy;
  assign done      = (state_q == ST_DONE);
  assign pix_count = pix_count_q;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    pix_count_d = pix_count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d  = ST_RUN;
          width_d  = width;
          height_d = height;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Finish as soon as the final entry is granted, not a cycle later.
        if (w_empty || (w_pop && (count_q == c_one))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_pop) begin
      rd_ptr_d    = rd_ptr_q + c_ptr_one;
      pix_count_d = pix_count_q + 16'd1;
    end

    if (w_push) begin
      fifo_addr_d[wr_ptr_q] = w_push_addr;
      fifo_data_d[wr_ptr_q] = pix_color;
      wr_ptr_d              = wr_ptr_q + c_ptr_one;
    end

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_one;
      2'b01:   count_d = count_q - c_one;
      default: count_d = count_q;
    endcase

    if (w_start) begin
      pix_count_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      pix_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      pix_count_q <= pix_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef PIXEL_FB_CLIP_STATS_EN
  logic        w_clip;
  logic [15:0] clip_count_q, clip_count_d;

  assign w_clip = w_xfer && !w_in_range;

  always_comb begin
    clip_count_d = clip_count_q;
    if (w_start) begin
      clip_count_d = '0;
    end else if (w_clip) begin
      clip_count_d = clip_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_count_q <= '0;
    end else begin
      clip_count_q <= clip_count_d;
    end
  end

  assign clip_count = clip_count_q;
`else
  assign clip_count = 16'd0;
`endif

endmodule
`default_nettype wire
